// File: rtl/piano_pkg.sv
// Shared constants for the key/voice bank: LFSR seed, feedback tap masks and a clog2 helper.
package piano_pkg;

   localparam logic [15:0] SEED = 16'hACE1;

   // Bit (e-1) set for every x^e term: x^8+x^6+x^5+x^4+1 and x^16+x^15+x^13+x^4+1
   localparam logic [15:0] TAPS_8  = 16'h00B8;
   localparam logic [15:0] TAPS_16 = 16'hD008;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/key_conditioner.sv
// One key input: 2-flop synchronizer followed by a stable-count debouncer.
module key_conditioner
   import piano_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYC = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic sw,
   output logic key_state
);

   localparam int unsigned CNT_W = (clog2(DEBOUNCE_CYC) > 0) ? clog2(DEBOUNCE_CYC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync_meta_q;
   logic             sync_q;
   logic             key_q;
   logic             key_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_meta_q <= 1'b0;
         sync_q      <= 1'b0;
         key_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         sync_meta_q <= sw;
         sync_q      <= sync_meta_q;
         key_q       <= key_d;
         cnt_q       <= cnt_d;
      end
   end

   // Any cycle where the synchronized level matches the accepted level restarts the count.
   always_comb begin
      cnt_d = '0;
      key_d = key_q;
      if (sync_q != key_q) begin
         if (cnt_q == LAST) begin
            key_d = sync_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   assign key_state = key_q;

endmodule

// File: rtl/key_voice_bank.sv
// Debounced key bank driving per-voice divided LFSR tone generators with a polyphony limit.
// Define KEY_VOICE_BANK_MIX_EN to build the voice mixer; otherwise mix_out is tied to 0.
module key_voice_bank
   import piano_pkg::*;
#(
   parameter int unsigned NUM_KEYS     = 8,
   parameter int unsigned LFSR_W       = 8,
   parameter int unsigned DEBOUNCE_CYC = 3,
   parameter int unsigned MAX_VOICES   = NUM_KEYS,
   parameter int unsigned DIV_W        = 12
) (
   input  logic                                  clk,
   input  logic                                  reset,
   input  logic [NUM_KEYS-1:0]                   sw,
   input  logic [NUM_KEYS*DIV_W-1:0]             div_cfg,
   output logic [NUM_KEYS-1:0]                   key_state,
   output logic [NUM_KEYS-1:0]                   voice_en,
   output logic [NUM_KEYS*LFSR_W-1:0]            lfsr_out,
   output logic [LFSR_W+clog2(NUM_KEYS+1)-1:0]   mix_out
);

   localparam logic [LFSR_W-1:0] SEED_W = SEED[LFSR_W-1:0];
   localparam logic [LFSR_W-1:0] TAPS_W =
      (LFSR_W == 16) ? TAPS_16[LFSR_W-1:0] : TAPS_8[LFSR_W-1:0];

   function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
      if (v == '0) return SEED_W;
      return {v[LFSR_W-2:0], ^(v & TAPS_W)};
   endfunction

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_conditioner #(
         .DEBOUNCE_CYC(DEBOUNCE_CYC)
      ) u_cond (
         .clk      (clk),
         .reset    (reset),
         .sw       (sw[k]),
         .key_state(key_state[k])
      );
   end

   logic [NUM_KEYS-1:0]              en_q;
   logic [NUM_KEYS-1:0]              en_d;
   logic [NUM_KEYS-1:0][LFSR_W-1:0]  lfsr_q;
   logic [NUM_KEYS-1:0][LFSR_W-1:0]  lfsr_d;
   logic [NUM_KEYS-1:0][DIV_W-1:0]   cnt_q;
   logic [NUM_KEYS-1:0][DIV_W-1:0]   cnt_d;

   // Lowest-index pressed keys win the available voices.
   always_comb begin
      int unsigned taken;
      taken = 0;
      en_d  = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (key_state[k] && (taken < MAX_VOICES)) begin
            en_d[k] = 1'b1;
            taken++;
         end
      end
   end

   always_comb begin
      logic [DIV_W-1:0] last;
      lfsr_d = '0;
      cnt_d  = '0;
      last   = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         last = div_cfg[k*DIV_W +: DIV_W];
         if (last != '0) last = last - DIV_W'(1);
         if (en_d[k] && !en_q[k]) begin
            lfsr_d[k] = SEED_W;
         end else if (en_d[k]) begin
            lfsr_d[k] = lfsr_q[k];
            // A count above a freshly lowered limit falls through to 0 without stepping.
            if (cnt_q[k] < last) begin
               cnt_d[k] = cnt_q[k] + DIV_W'(1);
            end else if (cnt_q[k] == last) begin
               lfsr_d[k] = lfsr_step(lfsr_q[k]);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q   <= '0;
         lfsr_q <= '0;
         cnt_q  <= '0;
      end else begin
         en_q   <= en_d;
         lfsr_q <= lfsr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign voice_en = en_q;
   assign lfsr_out = lfsr_q;

`ifdef KEY_VOICE_BANK_MIX_EN
   localparam int unsigned MIX_W = LFSR_W + clog2(NUM_KEYS + 1);

   logic [MIX_W-1:0] mix_q;
   logic [MIX_W-1:0] mix_d;

   always_comb begin
      mix_d = '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
         if (en_q[k]) mix_d = mix_d + MIX_W'(lfsr_q[k]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mix_q <= '0;
      end else begin
         mix_q <= mix_d;
      end
   end

   assign mix_out = mix_q;
`else
   assign mix_out = '0;
`endif

endmodule

// File: tb/tb_key_voice_bank.sv
// Bench for key_voice_bank: an unlimited-polyphony instance and a 2-voice instance share stimulus.
module tb_key_voice_bank;
   import piano_pkg::*;

   localparam int NK = 8;
   localparam int LW = 8;
   localparam int DB = 3;
   localparam int DW = 12;
   localparam int MW = 12;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [NK-1:0]    sw = '0;
   logic [NK*DW-1:0] div_cfg = '0;
   logic [NK-1:0]    ks_a, ks_b, ve_a, ve_b;
   logic [NK*LW-1:0] lf_a, lf_b;
   logic [MW-1:0]    mx_a, mx_b;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   key_voice_bank #(
      .NUM_KEYS(NK), .LFSR_W(LW), .DEBOUNCE_CYC(DB), .MAX_VOICES(NK), .DIV_W(DW)
   ) dut_a (
      .clk(clk), .reset(reset), .sw(sw), .div_cfg(div_cfg),
      .key_state(ks_a), .voice_en(ve_a), .lfsr_out(lf_a), .mix_out(mx_a)
   );

   key_voice_bank #(
      .NUM_KEYS(NK), .LFSR_W(LW), .DEBOUNCE_CYC(DB), .MAX_VOICES(2), .DIV_W(DW)
   ) dut_b (
      .clk(clk), .reset(reset), .sw(sw), .div_cfg(div_cfg),
      .key_state(ks_b), .voice_en(ve_b), .lfsr_out(lf_b), .mix_out(mx_b)
   );

   // Reference model: index 0 mirrors dut_a, index 1 mirrors dut_b.
   bit [NK-1:0]          m_s1, m_s2, m_key;
   int                   m_run [NK];
   bit [NK-1:0]          m_en [2];
   bit [NK-1:0][LW-1:0]  m_lfsr [2];
   int unsigned          m_cnt [2][NK];
   bit [MW-1:0]          m_mix [2];

   function automatic bit [LW-1:0] lfsr_next(bit [LW-1:0] v);
      int taps [4] = '{8, 6, 5, 4};
      bit fb = 1'b0;
      if (v == 0) return SEED[LW-1:0];
      foreach (taps[j]) fb ^= v[taps[j]-1];
      return {v[LW-2:0], fb};
   endfunction

   function automatic void model_clear();
      m_s1 = '0; m_s2 = '0; m_key = '0;
      for (int k = 0; k < NK; k++) m_run[k] = 0;
      for (int i = 0; i < 2; i++) begin
         m_en[i] = '0; m_lfsr[i] = '0; m_mix[i] = '0;
         for (int k = 0; k < NK; k++) m_cnt[i][k] = 0;
      end
   endfunction

   function automatic void model_edge();
      bit [NK-1:0] en_n;
      int unsigned taken, lim, d;
      for (int i = 0; i < 2; i++) begin
         lim = (i == 0) ? NK : 2;
         taken = 0;
         en_n = '0;
         for (int k = 0; k < NK; k++)
            if (m_key[k] && taken < lim) begin en_n[k] = 1'b1; taken++; end
         m_mix[i] = '0;
         for (int k = 0; k < NK; k++) if (m_en[i][k]) m_mix[i] += MW'(m_lfsr[i][k]);
         for (int k = 0; k < NK; k++) begin
            d = div_cfg[k*DW +: DW];
            if (d == 0) d = 1;
            if (!en_n[k]) begin
               m_lfsr[i][k] = '0; m_cnt[i][k] = 0;
            end else if (!m_en[i][k]) begin
               m_lfsr[i][k] = SEED[LW-1:0]; m_cnt[i][k] = 0;
            end else if (m_cnt[i][k] == d - 1) begin
               m_cnt[i][k] = 0; m_lfsr[i][k] = lfsr_next(m_lfsr[i][k]);
            end else if (m_cnt[i][k] > d - 1) begin
               m_cnt[i][k] = 0;
            end else begin
               m_cnt[i][k]++;
            end
         end
         m_en[i] = en_n;
      end
      for (int k = 0; k < NK; k++) begin
         if (m_s2[k] != m_key[k]) begin
            m_run[k]++;
            if (m_run[k] == DB) begin m_key[k] = m_s2[k]; m_run[k] = 0; end
         end else begin
            m_run[k] = 0;
         end
      end
      m_s2 = m_s1;
      m_s1 = sw;
   endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) model_clear();
      else model_edge();
   end

   task automatic test_reset();
      reset = 1'b1; sw = '0; div_cfg = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (ks_a !== '0) begin errors++; $display("FAIL reset key_state got %h want 0", ks_a); end
      checks++; if (ve_a !== '0) begin errors++; $display("FAIL reset voice_en got %h want 0", ve_a); end
      checks++; if (lf_a !== '0) begin errors++; $display("FAIL reset lfsr_out got %h want 0", lf_a); end
      checks++; if (mx_a !== '0) begin errors++; $display("FAIL reset mix_out got %h want 0", mx_a); end
      checks++; if (ve_b !== '0) begin errors++; $display("FAIL reset voice_en_b got %h want 0", ve_b); end
      reset = 1'b0;
   endtask

   task automatic test_debounce_latency();
      @(negedge clk);
      sw[0] = 1'b1;
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         checks++;
         if (ks_a[0] !== 1'(n >= 5)) begin
            errors++; $display("FAIL latency key_state[0] edge %0d got %b want %b", n, ks_a[0], n >= 5);
         end
         checks++;
         if (ve_a[0] !== 1'(n >= 6)) begin
            errors++; $display("FAIL latency voice_en[0] edge %0d got %b want %b", n, ve_a[0], n >= 6);
         end
         if (n == 6) begin
            checks++;
            if (lf_a[LW-1:0] !== SEED[LW-1:0]) begin
               errors++; $display("FAIL latency lfsr0 got %h want %h", lf_a[LW-1:0], SEED[LW-1:0]);
            end
         end
      end
   endtask

   task automatic test_divider();
      logic [LW-1:0] prev;
      int steps;
      div_cfg[0 +: DW] = DW'(4);
      repeat (6) @(negedge clk);
      prev = lf_a[LW-1:0];
      steps = 0;
      repeat (40) begin
         @(negedge clk);
         if (lf_a[LW-1:0] !== prev) steps++;
         prev = lf_a[LW-1:0];
         checks++;
         if (lf_a !== m_lfsr[0] || lf_b !== m_lfsr[1]) begin
            errors++; $display("FAIL div4 lfsr got %h/%h want %h/%h", lf_a, lf_b, m_lfsr[0], m_lfsr[1]);
         end
      end
      checks++; if (steps != 10) begin errors++; $display("FAIL div4 step count got %0d want 10", steps); end
      div_cfg[0 +: DW] = '0;
      repeat (2) @(negedge clk);
      prev = lf_a[LW-1:0];
      steps = 0;
      repeat (20) begin
         @(negedge clk);
         if (lf_a[LW-1:0] !== prev) steps++;
         prev = lf_a[LW-1:0];
      end
      checks++; if (steps != 20) begin errors++; $display("FAIL div0 step count got %0d want 20", steps); end
   endtask

   task automatic test_glitch();
      @(negedge clk); sw[2] = 1'b1;
      @(negedge clk); sw[2] = 1'b0;
      repeat (10) begin
         @(negedge clk);
         checks++;
         if (ks_a[2] !== 1'b0 || ve_a[2] !== 1'b0) begin
            errors++; $display("FAIL glitch key2 state/en got %b%b want 00", ks_a[2], ve_a[2]);
         end
      end
   endtask

   task automatic test_polyphony();
      logic [NK-1:0] want_b, want_a;
      sw = 8'b0000_1011;
      repeat (10) @(negedge clk);
      want_b = 8'b0000_0011; want_a = 8'b0000_1011;
      checks++; if (ve_b !== want_b) begin errors++; $display("FAIL poly limit2 got %b want %b", ve_b, want_b); end
      checks++; if (ve_a !== want_a) begin errors++; $display("FAIL poly full got %b want %b", ve_a, want_a); end
      sw = 8'b0000_1010;
      repeat (10) @(negedge clk);
      want_b = 8'b0000_1010;
      checks++; if (ve_b !== want_b) begin errors++; $display("FAIL poly release got %b want %b", ve_b, want_b); end
   endtask

   task automatic test_mix();
      logic [MW-1:0] prev_sum, want;
      sw = 8'b0000_0011;
      div_cfg[0 +: DW] = DW'(2);
      div_cfg[DW +: DW] = DW'(3);
      repeat (10) @(negedge clk);
      checks++; if (ve_a !== 8'b0000_0011) begin errors++; $display("FAIL mix voices got %b want 00000011", ve_a); end
      prev_sum = MW'(m_lfsr[0][0]) + MW'(m_lfsr[0][1]);
      repeat (12) begin
         @(negedge clk);
`ifdef KEY_VOICE_BANK_MIX_EN
         want = prev_sum;
`else
         want = '0;
`endif
         checks++; if (mx_a !== want) begin errors++; $display("FAIL mix sum got %h want %h", mx_a, want); end
         prev_sum = MW'(m_lfsr[0][0]) + MW'(m_lfsr[0][1]);
      end
   endtask

   task automatic test_reset_midnote();
      int n;
      sw = 8'b0000_0111;
      div_cfg = '0;
      repeat (10) @(negedge clk);
      checks++; if (ve_a !== 8'b0000_0111) begin errors++; $display("FAIL midnote voices got %b want 00000111", ve_a); end
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      checks++; if (ks_a !== '0 || ve_a !== '0) begin
         errors++; $display("FAIL async reset key/en got %h/%h want 0/0", ks_a, ve_a);
      end
      checks++; if (lf_a !== '0 || mx_a !== '0) begin
         errors++; $display("FAIL async reset lfsr/mix got %h/%h want 0/0", lf_a, mx_a);
      end
      @(negedge clk);
      reset = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (ve_a[0] !== 1'b1 && n < 20);
      checks++; if (n != 2 + DB + 1) begin errors++; $display("FAIL retrigger edges got %0d want %0d", n, 2 + DB + 1); end
      checks++; if (lf_a[LW-1:0] !== SEED[LW-1:0] || lf_a[2*LW +: LW] !== SEED[LW-1:0]) begin
         errors++; $display("FAIL retrigger seed got %h want %h", lf_a, SEED[LW-1:0]);
      end
   endtask

   task automatic test_random();
      int hold = 0;
      logic [MW-1:0] want_a, want_b;
      repeat (600) begin
         @(negedge clk);
`ifdef KEY_VOICE_BANK_MIX_EN
         want_a = m_mix[0]; want_b = m_mix[1];
`else
         want_a = '0; want_b = '0;
`endif
         checks++; if (ks_a !== m_key) begin errors++; $display("FAIL rand key_state got %b want %b", ks_a, m_key); end
         checks++; if (ve_a !== m_en[0] || ve_b !== m_en[1]) begin
            errors++; $display("FAIL rand voice_en got %b/%b want %b/%b", ve_a, ve_b, m_en[0], m_en[1]);
         end
         checks++; if (lf_a !== m_lfsr[0] || lf_b !== m_lfsr[1]) begin
            errors++; $display("FAIL rand lfsr got %h/%h want %h/%h", lf_a, lf_b, m_lfsr[0], m_lfsr[1]);
         end
         checks++; if (mx_a !== want_a || mx_b !== want_b) begin
            errors++; $display("FAIL rand mix got %h/%h want %h/%h", mx_a, mx_b, want_a, want_b);
         end
         if (hold == 0) begin
            sw = NK'($urandom);
            hold = $urandom_range(1, 8);
         end else begin
            hold--;
         end
         if ($urandom_range(0, 15) == 0)
            for (int k = 0; k < NK; k++) div_cfg[k*DW +: DW] = DW'($urandom_range(0, 6));
      end
   endtask

   initial begin
      test_reset();
      test_debounce_latency();
      test_divider();
      test_glitch();
      test_polyphony();
      test_mix();
      test_reset_midnote();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/key_voice_bank.md
KEY_VOICE_BANK -- requirements
Module: key_voice_bank

Interface
REQ-001 SHALL have parameter NUM_KEYS, default 8, meaning number of key inputs and voices (1..16).
REQ-002 SHALL have parameter LFSR_W, default 8, meaning per-voice LFSR width (8 or 16 only).
REQ-003 SHALL have parameter DEBOUNCE_CYC, default 3, meaning consecutive stable cycles required to accept a key change (>=1).
REQ-004 SHALL have parameter MAX_VOICES, default NUM_KEYS, meaning polyphony limit (1..NUM_KEYS).
REQ-005 SHALL have parameter DIV_W, default 12, meaning per-voice divisor width.
REQ-006 SHALL have one clock and an asynchronous, active-high reset.
REQ-007 clk  input  1  system clock; all state updates on its rising edge.
REQ-008 reset  input  1  asynchronous active-high reset.
REQ-009 sw  input  NUM_KEYS  raw asynchronous key switches, bit k = key k.
REQ-010 div_cfg  input  NUM_KEYS*DIV_W  per-voice step divisor, slice k for voice k; 0 treated as 1.
REQ-011 key_state  output  NUM_KEYS  debounced key levels.
REQ-012 voice_en  output  NUM_KEYS  registered voice enables after polyphony limit.
REQ-013 lfsr_out  output  NUM_KEYS*LFSR_W  per-voice LFSR values, slice k for voice k.
REQ-014 mix_out  output  LFSR_W+clog2(NUM_KEYS+1)  registered sum of active voice values.

Function
REQ-015 Each sw bit SHALL pass a 2-flop synchronizer; s_k denotes the second-stage output.
REQ-016 Per key, counter SHALL clear when s_k == key_state[k], increment when they differ, and on reaching DEBOUNCE_CYC-1 while differing update key_state[k] <= s_k and clear.
REQ-017 A single-cycle glitch on sw SHALL never change key_state.
REQ-018 A clean level change on sw SHALL appear on key_state exactly 2+DEBOUNCE_CYC rising edges after first sampling.
REQ-019 voice_en SHALL register, one cycle after key_state, the lowest-index MAX_VOICES set bits of key_state; higher-index pressed keys get 0.
REQ-020 On the edge where voice_en[k] goes 0->1, lfsr_k SHALL load SEED and div counter SHALL load 0.
REQ-021 While voice_en[k]=1, div counter SHALL count 0..D-1 (D = max(div_cfg slice,1)); at D-1 it SHALL wrap to 0 and lfsr_k SHALL shift one Fibonacci step using the package tap mask.
REQ-022 If lfsr_k is ever 0 while enabled, the next step SHALL reload SEED (no lockup).
REQ-023 While voice_en[k]=0, lfsr_k and its div counter SHALL be 0.
REQ-024 div_cfg changes SHALL take effect at the next counter comparison; if the new D-1 is below the current count, the counter SHALL wrap to 0 on the next edge without stepping.
REQ-025 mix_out SHALL equal, one cycle later, the unsigned sum of lfsr_out slices of enabled voices, with no overflow (width per REQ-014).

Reset
REQ-026 Reset SHALL clear synchronizers, debounce counters, key_state, voice_en, all LFSRs, div counters and mix_out to 0 immediately.
REQ-027 Reset asserted mid-note SHALL silence all voices; after release, a held key SHALL re-trigger via the debounce path from the SEED value.

Configuration
REQ-028 Macro KEY_VOICE_BANK_MIX_EN: when defined, the mixer per REQ-025 is built; when undefined, mix_out SHALL be constant 0 and no adder logic SHALL exist.

Structure
REQ-029 Package piano_pkg SHALL hold SEED, tap masks for widths 8 (x^8+x^6+x^5+x^4+1) and 16 (x^16+x^15+x^13+x^4+1), and the clog2 helper.
REQ-030 Synchronizer plus debounce SHALL be a sub-module key_conditioner, instantiated NUM_KEYS times.

Verification
REQ-031 sw[0] 0->1 held, DEBOUNCE_CYC=3 -> key_state[0]=1 after edge 5, voice_en[0]=1 after edge 6, lfsr_out[7:0]=SEED on edge 6.
REQ-032 1-cycle pulse on sw[2] -> key_state and voice_en remain 0.
REQ-033 MAX_VOICES=2, sw=8'b00001011 -> voice_en=8'b00000011; release key 0 -> voice_en=8'b00001010.
REQ-034 div_cfg slice0=4, key 0 held -> lfsr_0 steps every 4th cycle; div 0 -> steps every cycle.
REQ-035 Keys 0 and 1 active, MIX_EN defined -> mix_out = lfsr_0+lfsr_1 one cycle later; undefined -> mix_out=0.
REQ-036 Reset asserted with 3 voices active -> all outputs 0 asynchronously; after release with keys held, voices restart at SEED after 2+DEBOUNCE_CYC+1 edges.
